mem16_resp: RTL and testbench
=============================

# mem16_resp

Memory-side responder for the 16-bit datapath's request/acknowledge bus. It accepts read, write and OR-set requests from a bus initiator, holds a 2^ADDR_W x 16 word store, and applies a programmable number of wait states. It answers every request with a four-phase acknowledge. OR-set is the same bitwise OR used by the datapath's 16-bit OR unit, applied here as an atomic read-modify-write on the stored word.

## Interface
- ADDR_W, 8: word address width; store depth is 2^ADDR_W words.
- WAIT, 2: wait cycles inserted before each access; legal range 0..15.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  initiator request; four-phase, held high until ack seen.
- op  in  2  operation: 00 read, 01 write, 10 OR-set, 11 illegal.
- addr  in  ADDR_W  word address.
- wdata  in  16  write / OR operand.
- rdata  out  16  read result, valid while ack=1.
- ack  out  1  acknowledge.
- err  out  1  error flag, valid while ack=1.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - WAIT: counting wait cycles; down-counter cnt is 4 bits.
  - ACK: acknowledge asserted.
- Reset value of every output is 0 (rdata=16'h0000, ack=0, err=0), with state=IDLE and cnt=0.
- Reset does not initialise store contents; they are undefined until written.
- IDLE: on an edge with req=1, the block captures op, addr and wdata into registers, loads cnt=WAIT and moves to WAIT. After capture, changes on the inputs have no effect.
- WAIT: on an edge with cnt!=0, cnt decrements. On the edge with cnt==0, the access is performed from the captured values, the block moves to ACK, and ack=1.
- Access rules, by op:
  - Read (00): rdata = mem[addr]; err=0.
  - Write (01): mem[addr] = wdata; rdata = previous mem[addr]; err=0.
  - OR-set (10): mem[addr] = mem[addr] | wdata, bitwise over all 16 bits; rdata = previous mem[addr]; err=0.
  - Illegal (11): store unchanged; rdata=0; err=1.
- ACK: ack, rdata and err hold while req=1. On the edge with req=0, the block moves to IDLE and ack, err and rdata clear to 0. A new request is accepted only from IDLE, so req must go low between transactions.
- Early req drop during WAIT is a protocol violation with defined behaviour:
  - The access still completes.
  - ACK is entered and then, because req=0, left on the next edge: ack pulses for exactly 1 cycle.
- Reset mid-transaction:
  - Asserted before the access edge: no store update occurs.
  - Asserted in ACK: the already-performed update stands.
  - In both cases, outputs drop to 0 immediately, without waiting for a clock edge.
- Address wrap: not applicable; addr spans the full depth.

## Timing
- Accept edge E0 is the first rising edge in IDLE with req=1.
- The access and the ack rise occur at edge E0+WAIT+1. Examples: WAIT=0 gives ack 1 cycle after E0; WAIT=2 gives 3 cycles after E0.
- ack falls at the first edge in ACK that sees req=0. With the minimum four-phase exchange, each transaction occupies WAIT+2 cycles plus initiator turnaround.
- The earliest next accept is the edge after ack falls, if req is high again.
- rdata and err are registered and change only on the same edges as ack.
- Back-to-back transactions to the same address see the prior write: no read-after-write hazard, because accesses are serialised by the FSM.

## Test plan
- Reset, WAIT=2: assert rst mid-cycle -> ack=0, err=0, rdata=0000 immediately, without waiting for a clock edge; deassert -> IDLE, no ack while req=0.
- Write then read: write addr 8'h10 = 16'h00FF; then read 8'h10 -> ack rises exactly 3 edges after each accept; read returns rdata=00FF, err=0.
- OR-set:
  - mem[8'h10]=00FF, OR-set wdata=FFFF -> rdata=00FF, a following read returns FFFF.
  - mem[8'h20]=0000, OR-set FF00 -> a following read returns FF00.
- Illegal op: op=11 at 8'h10 -> ack with err=1, rdata=0000; a following read of 8'h10 returns the unchanged FFFF.
- Handshake holding: keep req high 5 cycles after ack -> ack, rdata and err stable for the whole period; drop req -> ack=0 on the next edge, IDLE; re-raise req -> new accept.
- Early drop and mid-operation reset:
  - Drop req one cycle after accept of write 8'h30=1234 -> ack pulses exactly 1 cycle, and a later read returns 1234.
  - Write 8'h31=ABCD, assert rst during WAIT -> a later read of 8'h31 returns its pre-reset value (previously written 5555).

Source files
------------

// File: rtl/mem16_resp.sv
// mem16_resp: word-store responder on the four-phase request/acknowledge bus.
// Accepts read, write and OR-set requests, inserts WAIT wait cycles, then
// performs a single access and holds the acknowledge until req drops.
module mem16_resp #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              ack,
  output logic              err
);

  localparam int          DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_OR    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [15:0]         rdata_q, rdata_d;

  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;

  logic [15:0]         mem [DEPTH];
  logic [15:0]         mem_rd;
  logic [15:0]         mem_wdata;
  logic                mem_we;

  // Bitwise OR shared with the datapath's OR unit; used for the read-modify-write.
  function automatic logic [15:0] or_set(input logic [15:0] cur, input logic [15:0] operand);
    return cur | operand;
  endfunction

  // Store is read combinationally from the captured address only.
  assign mem_rd = mem[addr_q];

  // Next-state, capture and access decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;
    mem_wdata = mem_rd;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_CNT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The access happens on this edge regardless of req; an early
          // drop simply makes the following ACK last one cycle.
          state_d = ST_ACK;
          ack_d   = 1'b1;
          unique case (op_q)
            OP_READ: begin
              rdata_d = mem_rd;
              err_d   = 1'b0;
            end
            OP_WRITE: begin
              rdata_d   = mem_rd;
              err_d     = 1'b0;
              mem_we    = 1'b1;
              mem_wdata = wdata_q;
            end
            OP_OR: begin
              rdata_d   = mem_rd;
              err_d     = 1'b0;
              mem_we    = 1'b1;
              mem_wdata = or_set(mem_rd, wdata_q);
            end
            default: begin
              rdata_d = 16'h0000;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_ACK: begin
        if (!req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = 16'h0000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = 16'h0000;
      end
    endcase
  end

  // Control and response registers; reset clears them without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Captured request fields; only meaningful once a request has been accepted.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Word store; contents are not reset, and reset blocks any pending update.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem16_resp.sv
// Bench for mem16_resp: directed table, multi-cycle corner sequences and a
// randomized phase checked against a simple array model of the store.
module tb_mem16_resp;

  localparam int WAIT_C = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  op;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;

  int n_pass;
  int n_total;

  mem16_resp #(.ADDR_W(8), .WAIT(WAIT_C)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One four-phase transaction: accept, scramble inputs, wait for ack,
  // optionally hold req, then drop req and confirm the outputs clear.
  task automatic txn(input logic [1:0] o, input logic [7:0] a, input logic [15:0] d,
                     input int hold, output logic [15:0] rd, output logic e);
    int lat;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    op = 2'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
    lat = 0;
    while (!ack && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, WAIT_C + 1);
    rd = rdata;
    e  = err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_ack", ack, 1);
      chk("hold_rdata", rdata, rd);
      chk("hold_err", err, e);
    end
    req = 1'b0;
    @(posedge clk); #1;
    chk("ack_fall", ack, 0);
    chk("rdata_clr", rdata, 0);
    chk("err_clr", err, 0);
  endtask

  vec_t        vecs[$];
  logic [15:0] rd;
  logic        e;
  logic [15:0] model_mem [256];
  logic        model_known [256];
  int          ack_cnt;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1; req = 1'b0; op = 2'b00; addr = 8'h00; wdata = 16'h0000;
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;

    vecs.push_back('{2'b01, 8'h10, 16'h00FF, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{2'b00, 8'h10, 16'h1111, 1'b1, 16'h00FF, 1'b0});
    vecs.push_back('{2'b10, 8'h10, 16'hFFFF, 1'b1, 16'h00FF, 1'b0});
    vecs.push_back('{2'b00, 8'h10, 16'h2222, 1'b1, 16'hFFFF, 1'b0});
    vecs.push_back('{2'b01, 8'h20, 16'h0000, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{2'b10, 8'h20, 16'hFF00, 1'b1, 16'h0000, 1'b0});
    vecs.push_back('{2'b00, 8'h20, 16'h3333, 1'b1, 16'hFF00, 1'b0});
    vecs.push_back('{2'b11, 8'h10, 16'h0F0F, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{2'b00, 8'h10, 16'h4444, 1'b1, 16'hFFFF, 1'b0});
    vecs.push_back('{2'b01, 8'h31, 16'h5555, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{2'b00, 8'h31, 16'h0000, 1'b1, 16'h5555, 1'b0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_ack", ack, 0);

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, 0, rd, e);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
    end

    // Handshake holding, then immediate re-accept
    txn(2'b00, 8'h20, 16'h0000, 5, rd, e);
    chk("hold_read_rdata", rd, 16'hFF00);
    txn(2'b00, 8'h10, 16'h0000, 0, rd, e);
    chk("reaccept_rdata", rd, 16'hFFFF);

    // Early req drop during WAIT: ack pulses exactly one cycle
    @(negedge clk);
    req = 1'b1; op = 2'b01; addr = 8'h30; wdata = 16'h1234;
    @(posedge clk); #1;
    req = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) ack_cnt++;
    end
    chk("early_drop_ack_pulses", ack_cnt, 1);
    txn(2'b00, 8'h30, 16'h0000, 0, rd, e);
    chk("early_drop_rdata", rd, 16'h1234);

    // Reset during WAIT: the write never lands
    @(negedge clk);
    req = 1'b1; op = 2'b01; addr = 8'h31; wdata = 16'hABCD;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_wait_ack", ack, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    txn(2'b00, 8'h31, 16'h0000, 0, rd, e);
    chk("rst_wait_rdata", rd, 16'h5555);

    // Reset mid-cycle while in ACK: outputs drop at once, update stands
    @(negedge clk);
    req = 1'b1; op = 2'b01; addr = 8'h40; wdata = 16'h7777;
    ack_cnt = 0;
    while (!ack && ack_cnt < 40) begin
      @(posedge clk); #1;
      ack_cnt++;
    end
    chk("rst_ack_reached", ack, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ack", ack, 0);
    chk("rst_async_err", err, 0);
    chk("rst_async_rdata", rdata, 0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle_no_ack", ack, 0);
    txn(2'b00, 8'h40, 16'h0000, 0, rd, e);
    chk("rst_ack_update_stands", rd, 16'h7777);

    // Randomized phase against the array model
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  r_op;
      logic [7:0]  r_addr;
      logic [15:0] r_wd;
      logic [15:0] exp_rd;
      logic        exp_e;
      logic        rd_known;
      r_op   = 2'($urandom_range(0, 3));
      r_addr = 8'h80 + 8'($urandom_range(0, 7));
      r_wd   = 16'($urandom);
      rd_known = model_known[r_addr];
      exp_rd   = model_mem[r_addr];
      exp_e    = 1'b0;
      if (r_op == 2'b11) begin
        exp_rd   = 16'h0000;
        exp_e    = 1'b1;
        rd_known = 1'b1;
      end else if (r_op == 2'b01) begin
        model_mem[r_addr]   = r_wd;
        model_known[r_addr] = 1'b1;
      end else if (r_op == 2'b10) begin
        if (model_known[r_addr]) model_mem[r_addr] = model_mem[r_addr] | r_wd;
      end
      txn(r_op, r_addr, r_wd, $urandom_range(0, 2), rd, e);
      if (rd_known) chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rand%0d_err", i), e, exp_e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
